// File: rtl/cache_pkg.sv
// cache_pkg: shared sizing, FSM states and grant encoding for the cache fill arbiter
package cache_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS = 8;
  localparam int MEM_LAT = 4;
  localparam int BLOCK_OFF = 4;
  typedef enum logic [1:0] {IDLE, FILL, META} state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;
endpackage

// File: rtl/fill_counter.sv
// fill_counter: issue and return word counters for one block fill, saturating at WORDS
module fill_counter
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       issue_inc,
  input  logic       ret_inc,
  output logic [3:0] issue_cnt,
  output logic [3:0] ret_cnt,
  output logic       issue_full,
  output logic       ret_full
);
  assign issue_full = issue_cnt == 4'(WORDS);
  assign ret_full = ret_cnt == 4'(WORDS);
  always_ff @(posedge clk)
    if (rst || clr) begin
      issue_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (issue_inc && !issue_full) issue_cnt <= issue_cnt + 4'd1;
      if (ret_inc && !ret_full) ret_cnt <= ret_cnt + 4'd1;
    end
endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: grants I/D cache misses to memory and streams the block back into the winner
module cache_fill_arbiter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              i_data_we,
  output logic              d_data_we,
  output logic              i_meta_we,
  output logic              d_meta_we,
  output logic              icache_fill_done,
  output logic              dcache_fill_done,
  output logic              busy
);
  state_t state;
  gnt_t gnt;
  logic [ADDR_W-1:0] base, req_addr;
  logic [3:0] issue_cnt, ret_cnt;
  logic issue_full, ret_full, wr;
  fill_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != FILL),
    .issue_inc(mem_rd_en),
    .ret_inc(wr),
    .issue_cnt(issue_cnt),
    .ret_cnt(ret_cnt),
    .issue_full(issue_full),
    .ret_full(ret_full)
  );
  always_comb begin
    req_addr = dcache_miss ? dcache_addr : icache_addr;
    mem_rd_en = state == FILL && !issue_full;
    mem_addr = mem_rd_en ? base | ADDR_W'({issue_cnt[2:0], 1'b0}) : '0;
    wr = state == FILL && mem_rd_valid && !ret_full;
    fill_data = wr ? mem_rd_data : '0;
    fill_word = wr ? ret_cnt[2:0] : '0;
    i_data_we = wr && gnt == GNT_I;
    d_data_we = wr && gnt == GNT_D;
    i_meta_we = state == META && gnt == GNT_I;
    d_meta_we = state == META && gnt == GNT_D;
    icache_fill_done = i_meta_we;
    dcache_fill_done = d_meta_we;
    busy = state != IDLE;
  end
  // D wins ties: its miss comes from the older MEM stage
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gnt <= GNT_I;
      base <= '0;
    end else begin
      state <= state == IDLE ? (dcache_miss || icache_miss ? FILL : IDLE)
             : state == FILL ? (wr && ret_cnt == 4'(WORDS - 1) ? META : FILL)
             : IDLE;
      if (state == IDLE) begin
        gnt <= dcache_miss ? GNT_D : GNT_I;
        base <= req_addr & ~ADDR_W'((1 << BLOCK_OFF) - 1);
      end
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: directed checks of grant order, fill sequencing, reset abort and spurious returns
module tb_cache_fill_arbiter;
  logic clk = 0, rst = 1;
  logic icache_miss = 0, dcache_miss = 0;
  logic [15:0] icache_addr = 0, dcache_addr = 0;
  logic mem_rd_en, mem_rd_valid;
  logic [15:0] mem_addr, mem_rd_data, fill_data;
  logic [2:0] fill_word;
  logic i_data_we, d_data_we, i_meta_we, d_meta_we, icache_fill_done, dcache_fill_done, busy;
  logic spur_v = 0;
  logic [15:0] spur_d = 0;
  logic [3:0] vpipe = '0;
  logic [15:0] apipe [4];
  int checks = 0, failures = 0;

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_we(i_data_we), .d_data_we(d_data_we),
    .i_meta_we(i_meta_we), .d_meta_we(d_meta_we),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // memory model: fixed 4-cycle latency, data = address ^ 5A5A
  always @(posedge clk) begin
    vpipe <= {vpipe[2:0], mem_rd_en};
    apipe[0] <= mem_addr;
    for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_rd_valid = vpipe[3] | spur_v;
  assign mem_rd_data = spur_v ? spur_d : apipe[3] ^ 16'h5A5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic quiet(input string tag);
    check({tag, " i_we"}, i_data_we, 0);
    check({tag, " d_we"}, d_data_we, 0);
    check({tag, " i_meta"}, i_meta_we, 0);
    check({tag, " d_meta"}, d_meta_we, 0);
    check({tag, " i_done"}, icache_fill_done, 0);
    check({tag, " d_done"}, dcache_fill_done, 0);
  endtask

  // Called at a negedge in the IDLE cycle that sees the miss (k=0); returns at the negedge after META.
  // An extra valid is injected in the META cycle to confirm it writes nothing.
  task automatic fill(input string tag, input bit d, input logic [15:0] base, input int drop_k);
    logic en, w, m;
    logic [15:0] a;
    for (int k = 0; k <= 13; k++) begin
      en = k >= 1 && k <= 8;
      w = k >= 5 && k <= 12;
      m = k == 13;
      if (m) begin
        spur_v = 1;
        spur_d = 16'hBEEF;
      end
      #1;
      check({tag, " rd_en"}, mem_rd_en, en);
      if (en) check({tag, " mem_addr"}, mem_addr, base + 16'(2 * (k - 1)));
      if (w) begin
        a = base + 16'(2 * (k - 5));
        check({tag, " fill_word"}, fill_word, k - 5);
        check({tag, " fill_data"}, fill_data, a ^ 16'h5A5A);
      end
      check({tag, " i_we"}, i_data_we, w && !d);
      check({tag, " d_we"}, d_data_we, w && d);
      check({tag, " i_meta"}, i_meta_we, m && !d);
      check({tag, " d_meta"}, d_meta_we, m && d);
      check({tag, " i_done"}, icache_fill_done, m && !d);
      check({tag, " d_done"}, dcache_fill_done, m && d);
      check({tag, " busy"}, busy, k >= 1);
      spur_v = 0;
      if (k == drop_k || m) begin
        if (d) dcache_miss = 0;
        else icache_miss = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset rd_en", mem_rd_en, 0);
    quiet("reset");
    rst = 0;
    @(negedge clk);

    // single D miss, spurious IDLE valid first
    spur_v = 1;
    spur_d = 16'hBEEF;
    #1;
    quiet("idle spurious");
    check("idle spurious busy", busy, 0);
    spur_v = 0;
    @(negedge clk);
    dcache_miss = 1;
    dcache_addr = 16'h1236;
    fill("d single", 1, 16'h1230, -1);
    #1;
    check("d single after busy", busy, 0);
    @(negedge clk);

    // simultaneous: D first, I right after
    icache_miss = 1;
    icache_addr = 16'h0040;
    dcache_miss = 1;
    dcache_addr = 16'h2000;
    fill("both d", 1, 16'h2000, -1);
    fill("both i", 0, 16'h0040, -1);
    #1;
    check("both after busy", busy, 0);
    @(negedge clk);

    // I only at top of address space
    icache_miss = 1;
    icache_addr = 16'hFFF0;
    fill("i top", 0, 16'hFFF0, -1);
    @(negedge clk);

    // D miss dropped mid-fill still completes, done only once
    dcache_miss = 1;
    dcache_addr = 16'h3456;
    fill("d drop", 1, 16'h3450, 2);
    #1;
    check("d drop no second done", dcache_fill_done, 0);
    check("d drop idle", busy, 0);
    @(negedge clk);

    // reset on the 3rd FILL cycle
    dcache_miss = 1;
    dcache_addr = 16'h4000;
    repeat (3) @(negedge clk);
    #1;
    check("rst pre busy", busy, 1);
    check("rst pre rd_en", mem_rd_en, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    dcache_miss = 0;
    #1;
    check("rst busy", busy, 0);
    check("rst rd_en", mem_rd_en, 0);
    quiet("rst");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      quiet("rst inflight");
      check("rst inflight busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
